// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and write-back
// over one shared memory port, with a bounded wait on memory ready.
module mc_control_unit #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned WAIT_CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic [7:0] func,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic [2:0] alu_operation,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       R_sel,
   output logic       mem_to_reg,
   output logic       ld_window,
   output logic       illegal,
   output logic       bus_err
);

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_AND    = 3'b010;
   localparam logic [2:0] ALU_OR     = 3'b011;
   localparam logic [2:0] ALU_NOT    = 3'b100;
   localparam logic [2:0] ALU_PASS_B = 3'b101;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_JUMP  = 4'b0010;
   localparam logic [3:0] OP_BRZ   = 4'b0100;
   localparam logic [3:0] OP_RTYPE = 4'b1000;
   localparam logic [3:0] OP_WND   = 4'b1010;
   localparam logic [3:0] OP_ADDI  = 4'b1100;
   localparam logic [3:0] OP_SUBI  = 4'b1101;
   localparam logic [3:0] OP_ANDI  = 4'b1110;
   localparam logic [3:0] OP_ORI   = 4'b1111;

   typedef enum logic [3:0] {
      ST_IF, ST_ID, ST_EX_R, ST_EX_I, ST_WB_ALU, ST_MEM_RD,
      ST_WB_MEM, ST_MEM_WR, ST_BR, ST_JMP, ST_WIN
   } state_t;

   state_t                state, state_next;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  mem_state_c, timeout_c, cnt_clr_c;
   logic                  r_legal_c, r_nop_c, is_itype_c;
   logic [2:0]            r_op_c, i_op_c;

   assign mem_state_c = (state == ST_IF) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
   assign timeout_c   = mem_state_c && !mem_ready && (wait_cnt == WAIT_CNT_W'(WAIT_LIMIT));
   // Any state change (incl. abort re-entering IF) starts a fresh wait window
   assign cnt_clr_c   = (state_next != state) || timeout_c;

   assign r_legal_c  = !func[7] && $onehot(func[6:0]);
   assign r_nop_c    = (func == 8'h00) || (func == 8'h80);
   assign is_itype_c = (opcode[3:2] == 2'b11);
   assign i_op_c     = {1'b0, opcode[1:0]};

   // R-type function decode; IR is stable from ID onward so WB reuses it
   always_comb begin
      r_op_c = ALU_ADD;
      if (func[0] || func[1]) r_op_c = ALU_PASS_B;
      else if (func[3])       r_op_c = ALU_SUB;
      else if (func[4])       r_op_c = ALU_AND;
      else if (func[5])       r_op_c = ALU_OR;
      else if (func[6])       r_op_c = ALU_NOT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IF;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (cnt_clr_c)
            wait_cnt <= '0;
         else if (mem_state_c && !mem_ready && (wait_cnt != WAIT_CNT_W'(WAIT_LIMIT)))
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end
   end

   always_comb begin
      state_next    = state;
      alu_operation = ALU_ADD;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      R_sel         = 1'b0;
      mem_to_reg    = 1'b0;
      ld_window     = 1'b0;
      illegal       = 1'b0;
      bus_err       = 1'b0;

      case (state)
         ST_IF: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = ST_ID;
            end else if (timeout_c) begin
               bus_err = 1'b1;
            end
         end
         ST_ID: begin
            case (opcode)
               OP_LOAD:  state_next = ST_MEM_RD;
               OP_STORE: state_next = ST_MEM_WR;
               OP_JUMP:  state_next = ST_JMP;
               OP_BRZ:   state_next = ST_BR;
               OP_WND:   state_next = ST_WIN;
               OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_next = ST_EX_I;
               OP_RTYPE: begin
                  if (r_legal_c)
                     state_next = ST_EX_R;
                  else begin
                     state_next = ST_IF;
                     illegal    = !r_nop_c;
                  end
               end
               default: begin
                  state_next = ST_IF;
                  illegal    = 1'b1;
               end
            endcase
         end
         ST_EX_R: begin
            alu_src_a     = 1'b1;
            alu_operation = r_op_c;
            state_next    = ST_WB_ALU;
         end
         ST_EX_I: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b10;
            alu_operation = i_op_c;
            state_next    = ST_WB_ALU;
         end
         ST_WB_ALU: begin
            reg_write     = 1'b1;
            alu_src_a     = 1'b1;
            alu_src_b     = is_itype_c ? 2'b10 : 2'b00;
            alu_operation = is_itype_c ? i_op_c : r_op_c;
            R_sel         = !is_itype_c && func[0];
            state_next    = ST_IF;
         end
         ST_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready)
               state_next = ST_WB_MEM;
            else if (timeout_c) begin
               bus_err    = 1'b1;
               state_next = ST_IF;
            end
         end
         ST_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_next = ST_IF;
         end
         ST_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready)
               state_next = ST_IF;
            else if (timeout_c) begin
               bus_err    = 1'b1;
               state_next = ST_IF;
            end
         end
         ST_BR: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b11;
            alu_operation = ALU_SUB;
            if (zero_flag) begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
            end
            state_next = ST_IF;
         end
         ST_JMP: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            state_next = ST_IF;
         end
         ST_WIN: begin
            ld_window  = 1'b1;
            state_next = ST_IF;
         end
         default: state_next = ST_IF;
      endcase

      // Reset kills any in-flight request or strobe without waiting for a clock
      if (rst) begin
         alu_operation = '0;
         alu_src_a     = 1'b0;
         alu_src_b     = '0;
         pc_write      = 1'b0;
         pc_src        = '0;
         ir_write      = 1'b0;
         iord          = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         R_sel         = 1'b0;
         mem_to_reg    = 1'b0;
         ld_window     = 1'b0;
         illegal       = 1'b0;
         bus_err       = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle control vectors compared
// against hand-derived expectations for each instruction class.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'b0000;
   logic [7:0] func = 8'h00;
   logic       zero_flag = 1'b0;
   logic       mem_ready = 1'b0;
   logic [2:0] alu_operation;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write, iord, mem_read, mem_write, reg_write, R_sel;
   logic       mem_to_reg, ld_window, illegal, bus_err;

   // {op, src_a, src_b, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
   //  reg_write, R_sel, mem_to_reg, ld_window, illegal, bus_err}
   logic [18:0] obs;
   assign obs = {alu_operation, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, iord,
                 mem_read, mem_write, reg_write, R_sel, mem_to_reg, ld_window, illegal, bus_err};

   int checks = 0;
   int errors = 0;

   logic        rdy  [0:39];
   logic        zf   [0:39];
   logic [18:0] got  [0:39];
   logic [18:0] want [0:39];

   logic [18:0] v_if_rdy, v_if_wait, v_ill, v_rd, v_wbm, v_wr;

   always #5 clk = ~clk;

   mc_control_unit #(.WAIT_LIMIT(15), .WAIT_CNT_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero_flag(zero_flag),
      .mem_ready(mem_ready), .alu_operation(alu_operation), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .R_sel(R_sel), .mem_to_reg(mem_to_reg), .ld_window(ld_window), .illegal(illegal),
      .bus_err(bus_err)
   );

   // fl = {ir_write, iord, mem_read, mem_write, reg_write, R_sel, mem_to_reg, ld_window, illegal, bus_err}
   function automatic logic [18:0] ov(input logic [2:0] op, input logic a, input logic [1:0] b,
                                      input logic pcw, input logic [1:0] pcs, input logic [9:0] fl);
      return {op, a, b, pcw, pcs, fl};
   endfunction

   task automatic clear_stim();
      for (int i = 0; i < 40; i++) begin
         rdy[i]  = 1'b0;
         zf[i]   = 1'b0;
         want[i] = '0;
      end
   endtask

   // Apply per-cycle mem_ready/zero_flag, capture outputs mid-cycle; starts and ends at posedge+1
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         mem_ready = rdy[i];
         zero_flag = zf[i];
         @(negedge clk);
         got[i] = obs;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_ready = 1'b1;
      zero_flag = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %05h expected %05h", obs, 19'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_stim();
      want[0] = v_if_wait;
      run(1);
      checks++;
      if (got[0] !== want[0]) begin
         errors++;
         $display("FAIL first_fetch: got %05h expected %05h", got[0], want[0]);
      end
   endtask

   task automatic test_itype();
      for (int k = 0; k < 4; k++) begin
         clear_stim();
         opcode = 4'b1100 | 4'(k);
         func   = 8'h00;
         for (int i = 0; i < 4; i++) rdy[i] = 1'b1;
         want[0] = v_if_rdy;
         want[1] = '0;
         want[2] = ov(3'(k), 1'b1, 2'b10, 1'b0, 2'b00, 10'b0000000000);
         want[3] = ov(3'(k), 1'b1, 2'b10, 1'b0, 2'b00, 10'b0000100000);
         want[4] = v_if_wait;
         run(5);
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
               errors++;
               $display("FAIL itype op=%b cycle %0d: got %05h expected %05h", opcode, i, got[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_rtype();
      logic [3:0] t_op  [13];
      logic [7:0] t_fn  [13];
      logic [2:0] t_aop [13];
      logic       t_rs  [13];
      int         t_kd  [13];   // 0 legal, 1 nop, 2 illegal
      int         n;
      t_op  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                4'b1000, 4'b1000, 4'b1000, 4'b0011, 4'b1011, 4'b1000};
      t_fn  = '{8'h08, 8'h01, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40,
                8'h00, 8'h80, 8'h41, 8'h00, 8'h00, 8'hC0};
      t_aop = '{3'b001, 3'b101, 3'b101, 3'b000, 3'b010, 3'b011, 3'b100,
                3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
      t_rs  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      t_kd  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
      for (int e = 0; e < 13; e++) begin
         clear_stim();
         opcode  = t_op[e];
         func    = t_fn[e];
         rdy[0]  = 1'b1;
         rdy[1]  = 1'b1;
         want[0] = v_if_rdy;
         if (t_kd[e] == 0) begin
            rdy[2]  = 1'b1;
            rdy[3]  = 1'b1;
            want[1] = '0;
            want[2] = ov(t_aop[e], 1'b1, 2'b00, 1'b0, 2'b00, 10'b0000000000);
            want[3] = ov(t_aop[e], 1'b1, 2'b00, 1'b0, 2'b00, {4'b0000, 1'b1, t_rs[e], 4'b0000});
            want[4] = v_if_wait;
            n = 5;
         end else begin
            want[1] = (t_kd[e] == 2) ? v_ill : 19'd0;
            want[2] = v_if_wait;
            n = 3;
         end
         run(n);
         for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
               errors++;
               $display("FAIL rtype op=%b func=%h cycle %0d: got %05h expected %05h",
                        opcode, func, i, got[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_load();
      int waits [3];
      int w;
      waits = '{0, 3, 15};
      for (int k = 0; k < 3; k++) begin
         w = waits[k];
         clear_stim();
         opcode = 4'b0000;
         rdy[0] = 1'b1;
         rdy[1] = 1'b1;
         rdy[2 + w] = 1'b1;
         rdy[3 + w] = 1'b1;
         want[0] = v_if_rdy;
         want[1] = '0;
         for (int j = 0; j <= w; j++) want[2 + j] = v_rd;
         want[3 + w] = v_wbm;
         want[4 + w] = v_if_wait;
         run(5 + w);
         for (int i = 0; i < 5 + w; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
               errors++;
               $display("FAIL load waits=%0d cycle %0d: got %05h expected %05h", w, i, got[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_store();
      clear_stim();
      opcode = 4'b0001;
      rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1;
      want[0] = v_if_rdy; want[1] = '0; want[2] = v_wr; want[3] = v_if_wait;
      run(4);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL store cycle %0d: got %05h expected %05h", i, got[i], want[i]);
         end
      end
      // Memory never answers: abort on the 16th wait cycle, then refetch
      clear_stim();
      rdy[0] = 1'b1; rdy[1] = 1'b1;
      want[0] = v_if_rdy; want[1] = '0;
      for (int j = 2; j <= 16; j++) want[j] = v_wr;
      want[17] = v_wr | 19'd1;
      want[18] = v_if_wait;
      want[19] = v_if_wait;
      run(20);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL store_timeout cycle %0d: got %05h expected %05h", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_branch();
      for (int z = 0; z < 2; z++) begin
         clear_stim();
         opcode = 4'b0100;
         for (int i = 0; i < 4; i++) zf[i] = (z == 1);
         rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1;
         want[0] = v_if_rdy;
         want[1] = '0;
         want[2] = (z == 1) ? ov(3'b001, 1'b1, 2'b11, 1'b1, 2'b10, 10'b0)
                            : ov(3'b001, 1'b1, 2'b11, 1'b0, 2'b00, 10'b0);
         want[3] = v_if_wait;
         run(4);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
               errors++;
               $display("FAIL branch zf=%0d cycle %0d: got %05h expected %05h", z, i, got[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_jump_fetch_timeout();
      clear_stim();
      opcode = 4'b0010;
      rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1;
      want[0] = v_if_rdy;
      want[1] = '0;
      want[2] = ov(3'b000, 1'b0, 2'b00, 1'b1, 2'b01, 10'b0);
      for (int j = 3; j <= 17; j++) want[j] = v_if_wait;
      want[18] = v_if_wait | 19'd1;
      want[19] = v_if_wait;
      run(20);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL jump_fetch_timeout cycle %0d: got %05h expected %05h", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_window();
      clear_stim();
      opcode = 4'b1010;
      rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1;
      want[0] = v_if_rdy;
      want[1] = '0;
      want[2] = ov(3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 10'b0000000100);
      want[3] = v_if_wait;
      want[4] = v_if_wait;
      run(5);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL window cycle %0d: got %05h expected %05h", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_reset_midop();
      clear_stim();
      opcode = 4'b0001;
      rdy[0] = 1'b1; rdy[1] = 1'b1;
      want[0] = v_if_rdy; want[1] = '0; want[2] = v_wr; want[3] = v_wr; want[4] = v_wr;
      run(5);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL midop_pre cycle %0d: got %05h expected %05h", i, got[i], want[i]);
         end
      end
      mem_ready = 1'b0;
      #2;
      checks++;
      if (obs !== v_wr) begin
         errors++;
         $display("FAIL midop_wait: got %05h expected %05h", obs, v_wr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 19'd0) begin
         errors++;
         $display("FAIL midop_rst_async: got %05h expected %05h", obs, 19'd0);
      end
      @(negedge clk);
      checks++;
      if (obs !== 19'd0) begin
         errors++;
         $display("FAIL midop_rst_hold: got %05h expected %05h", obs, 19'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_stim();
      want[0] = v_if_wait;
      run(1);
      checks++;
      if (got[0] !== want[0]) begin
         errors++;
         $display("FAIL midop_refetch: got %05h expected %05h", got[0], want[0]);
      end
   endtask

   initial begin
      v_if_rdy  = ov(3'b000, 1'b0, 2'b01, 1'b1, 2'b00, 10'b1010000000);
      v_if_wait = ov(3'b000, 1'b0, 2'b01, 1'b0, 2'b00, 10'b0010000000);
      v_ill     = ov(3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 10'b0000000010);
      v_rd      = ov(3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 10'b0110000000);
      v_wbm     = ov(3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 10'b0000101000);
      v_wr      = ov(3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 10'b0101000000);
      test_reset();
      test_itype();
      test_rtype();
      test_load();
      test_store();
      test_branch();
      test_jump_fetch_timeout();
      test_window();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
